// File: rtl/udio_pkg.sv
// Board user-I/O constants shared by the input front end and the LED interface.
// Holds board widths, default debounce timing and pad polarity helpers.
package udio_pkg;

  localparam int N_SW          = 10;
  localparam int N_KEY         = 4;
  localparam int DB_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF     = 20;

  // Pad level that means "active" for each pin class, and the idle pad level.
  localparam logic KEY_ACTIVE_PAD = 1'b0;
  localparam logic KEY_IDLE_PAD   = 1'b1;
  localparam logic SW_ACTIVE_PAD  = 1'b1;
  localparam logic SW_IDLE_PAD    = 1'b0;

  typedef logic [N_SW-1:0]  sw_vec_t;
  typedef logic [N_KEY-1:0] key_vec_t;

  // Maps a raw pad level to an active-high value given the pad's active level.
  function automatic logic pad_to_active(input logic pad, input logic active_pad);
    return pad ~^ active_pad;
  endfunction

endpackage

// File: rtl/ud_debounce.sv
// One-pin front end: 2-flop synchroniser, stability counter, debounced level
// and registered rise/fall pulses; toggle flags the cycle before a level change.
module ud_debounce
  import udio_pkg::*;
#(
  parameter int   DB_CYCLES  = DB_CYCLES_DEF,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter logic IDLE_PAD   = 1'b0,
  parameter logic ACTIVE_PAD = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync0_r;
  logic             sync1_r;
  logic [CNT_W-1:0] cnt_r;
  logic             stable_r;
  logic             rise_r;
  logic             fall_r;
  logic             synced_s;
  logic             differ_s;
  logic             toggle_s;

  assign synced_s = pad_to_active(sync1_r, ACTIVE_PAD);
  assign differ_s = synced_s != stable_r;
  assign toggle_s = differ_s && (cnt_r == DB_LAST);

  // Two-flop synchroniser, parked at the idle pad level during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0_r <= IDLE_PAD;
      sync1_r <= IDLE_PAD;
    end else begin
      sync0_r <= pin;
      sync1_r <= sync0_r;
    end
  end

  // Stability counter: restarts whenever the input agrees with the stable level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!differ_s || toggle_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Accepted level and its edge pulses, all updated on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_r <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      stable_r <= stable_r ^ toggle_s;
      rise_r   <= toggle_s & ~stable_r;
      fall_r   <= toggle_s & stable_r;
    end
  end

  assign level  = stable_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign toggle = toggle_s;

endmodule

// File: rtl/udinput_interface.sv
// Board user-input front end: debounced switch/button levels and event pulses.
// Optional key auto-repeat is enabled by defining UDIN_AUTOREPEAT_EN.
module udinput_interface
  import udio_pkg::*;
#(
  parameter int N_SW          = udio_pkg::N_SW,
  parameter int N_KEY         = udio_pkg::N_KEY,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_KEY-1:0] KEY,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_change,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release
);

  logic [N_SW-1:0]  sw_level_s;
  logic [N_SW-1:0]  sw_rise_s;
  logic [N_SW-1:0]  sw_fall_s;
  logic [N_SW-1:0]  sw_toggle_s;
  logic [N_KEY-1:0] key_level_s;
  logic [N_KEY-1:0] key_rise_s;
  logic [N_KEY-1:0] key_fall_s;
  logic [N_KEY-1:0] key_toggle_s;
  logic             unused_ok_s;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    ud_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W),
      .IDLE_PAD  (SW_IDLE_PAD),
      .ACTIVE_PAD(SW_ACTIVE_PAD)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .pin   (SW[i]),
      .level (sw_level_s[i]),
      .rise  (sw_rise_s[i]),
      .fall  (sw_fall_s[i]),
      .toggle(sw_toggle_s[i])
    );
  end

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    ud_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W),
      .IDLE_PAD  (KEY_IDLE_PAD),
      .ACTIVE_PAD(KEY_ACTIVE_PAD)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .pin   (KEY[k]),
      .level (key_level_s[k]),
      .rise  (key_rise_s[k]),
      .fall  (key_fall_s[k]),
      .toggle(key_toggle_s[k])
    );
  end

  // Simultaneous switch flips collapse into one pulse.
  assign sw_level    = sw_level_s;
  assign sw_change   = |(sw_rise_s | sw_fall_s);
  assign key_level   = key_level_s;
  assign key_release = key_fall_s;

`ifdef UDIN_AUTOREPEAT_EN
  localparam int              R_W         = $clog2(REPEAT_DELAY + 1);
  localparam logic [R_W-1:0]  DELAY_LAST  = R_W'(REPEAT_DELAY - 1);
  localparam logic [R_W-1:0]  PERIOD_LAST = R_W'(REPEAT_PERIOD - 1);

  logic [N_KEY-1:0] rep_pulse_s;

  for (genvar k = 0; k < N_KEY; k++) begin : g_rep
    logic [R_W-1:0] rep_cnt_r;
    logic           rep_first_r;
    logic           rep_r;
    logic [R_W-1:0] rep_limit_s;

    assign rep_limit_s = rep_first_r ? PERIOD_LAST : DELAY_LAST;

    // Repeat timer; the release edge clears it so a repeat never meets key_release.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep_cnt_r   <= {R_W{1'b0}};
        rep_first_r <= 1'b0;
        rep_r       <= 1'b0;
      end else if (!key_level_s[k] || key_toggle_s[k]) begin
        rep_cnt_r   <= {R_W{1'b0}};
        rep_first_r <= 1'b0;
        rep_r       <= 1'b0;
      end else if (rep_cnt_r == rep_limit_s) begin
        rep_cnt_r   <= {R_W{1'b0}};
        rep_first_r <= 1'b1;
        rep_r       <= 1'b1;
      end else begin
        rep_cnt_r   <= rep_cnt_r + {{(R_W-1){1'b0}}, 1'b1};
        rep_r       <= 1'b0;
      end
    end

    assign rep_pulse_s[k] = rep_r;
  end

  assign key_press   = key_rise_s | rep_pulse_s;
  assign unused_ok_s = ^sw_toggle_s;
`else
  assign key_press   = key_rise_s;
  assign unused_ok_s = ^{sw_toggle_s, key_toggle_s, 1'(REPEAT_DELAY & REPEAT_PERIOD)};
`endif

endmodule

// File: tb/tb_udinput_interface.sv
// Scoreboard bench for udinput_interface: stimulus queues expected pulse events,
// a negedge monitor pops and compares every pulse the DUT presents.
module tb_udinput_interface;

  localparam int DB  = 8;
  localparam int LAT = DB + 2;
  localparam int RD  = 20;
  localparam int RP  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] sw_level;
  logic       sw_change;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic       chg;
    logic [9:0] swl;
    logic [3:0] kl;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [9:0] exp_swl = 10'h000;
  logic [3:0] exp_kl  = 4'h0;

  udinput_interface #(
    .DB_CYCLES    (DB),
    .CNT_W        (4),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SW         (SW),
    .KEY        (KEY),
    .sw_level   (sw_level),
    .sw_change  (sw_change),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic ch);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.chg = ch; e.swl = exp_swl; e.kl = exp_kl;
    q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    compared++;
    if (sw_level !== 10'h0 || sw_change !== 1'b0 || key_level !== 4'h0 ||
        key_press !== 4'h0 || key_release !== 4'h0) begin
      mismatched++;
      $display("FAIL %s: got sw=%h chg=%b key=%b press=%b rel=%b, want all zero",
               name, sw_level, sw_change, key_level, key_press, key_release);
    end
  endtask

  // Monitor: every cycle with a pulse must match the next queued event exactly.
  always @(negedge clk) begin
    if (key_press !== 4'h0 || key_release !== 4'h0 || sw_change !== 1'b0) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got cyc=%0d press=%b rel=%b chg=%b, want no event",
                 cyc, key_press, key_release, sw_change);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release ||
            e.chg !== sw_change || e.swl !== sw_level || e.kl !== key_level) begin
          mismatched++;
          $display("FAIL event: got cyc=%0d press=%b rel=%b chg=%b sw=%h key=%b, want cyc=%0d press=%b rel=%b chg=%b sw=%h key=%b",
                   cyc, key_press, key_release, sw_change, sw_level, key_level,
                   e.cyc, e.press, e.rel, e.chg, e.swl, e.kl);
        end
      end
    end
  end

  initial begin
    int a;
    rst = 1'b0;
    SW  = 10'h000;
    KEY = 4'hF;
    tick(2);

    // Pins wiggling while in reset must not reach any output.
    SW  = 10'h3FF;
    KEY = 4'h0;
    for (int i = 0; i < 3; i++) check_idle("reset_hold");
    SW  = 10'h000;
    KEY = 4'hF;
    tick(DB + 3);
    rst = 1'b1;
    tick(20);
    check_idle("post_reset_idle");

    // Clean press and release of KEY[0].
    tick(1);
    KEY[0] = 1'b0;
    exp_kl = 4'b0001;
    push(cyc + LAT, 4'b0001, 4'b0000, 1'b0);
    tick(15);
    KEY[0] = 1'b1;
    exp_kl = 4'b0000;
    push(cyc + LAT, 4'b0000, 4'b0001, 1'b0);
    tick(15);

    // SW[3] bounces every 3 cycles, then settles high.
    for (int i = 0; i < 10; i++) begin
      SW[3] = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(3);
    end
    SW[3] = 1'b1;
    exp_swl = 10'h008;
    push(cyc + LAT, 4'b0000, 4'b0000, 1'b1);
    tick(15);

    // SW[0] and SW[9] flip together, then three switches drop together.
    SW[0] = 1'b1;
    SW[9] = 1'b1;
    exp_swl = 10'h209;
    push(cyc + LAT, 4'b0000, 4'b0000, 1'b1);
    tick(15);
    SW = 10'h000;
    exp_swl = 10'h000;
    push(cyc + LAT, 4'b0000, 4'b0000, 1'b1);
    tick(15);

    // Reset at debounce count 5 with KEY[2] held through release.
    KEY[2] = 1'b0;
    tick(7);
    rst = 1'b0;
    check_idle("reset_mid_debounce");
    tick(3);
    rst = 1'b1;
    exp_kl = 4'b0100;
    push(cyc + LAT, 4'b0100, 4'b0000, 1'b0);
    tick(25);
    KEY[2] = 1'b1;
    exp_kl = 4'b0000;
    push(cyc + LAT, 4'b0000, 4'b0100, 1'b0);
    tick(15);

    // KEY[1] held well past acceptance.
    KEY[1] = 1'b0;
    a = cyc + LAT;
    exp_kl = 4'b0010;
    push(a, 4'b0010, 4'b0000, 1'b0);
`ifdef UDIN_AUTOREPEAT_EN
    for (int t = RD; t <= 50; t += RP) push(a + t, 4'b0010, 4'b0000, 1'b0);
`endif
    tick(LAT + 43);
    KEY[1] = 1'b1;
    exp_kl = 4'b0000;
    push(cyc + LAT, 4'b0000, 4'b0010, 1'b0);
    tick(30);

    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d events still pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
